bcd_conv_seq: RTL
=================

// Module: bcd_conv_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.
//  Replaces the purely combinational converter wherever wide counts (timer/stopwatch totals, dates) would
//  give a long combinational path. Sits between counter logic and the 7-segment digit mux.
//  Adds a valid/ready handshake, overflow detection and a leading-zero mask for display blanking.
// PARAMETERS
//  BIN_WIDTH   8  width of binary input, >= 1
//  BCD_DIGITS  3  number of output BCD digits, >= 1; any value allowed (overflow flagged, see BEHAVIOUR)
// PORTS
//  clk       in   1              single clock, rising edge
//  rst_n     in   1              asynchronous, active-low reset
//  in_valid  in   1              bin is valid
//  in_ready  out  1              converter can accept bin
//  bin       in   BIN_WIDTH      unsigned binary value
//  out_valid out  1              bcd/overflow/lz_mask valid
//  out_ready in   1              consumer accepts result
//  bcd       out  4*BCD_DIGITS   packed digits, digit 0 (ones) at [3:0]
//  overflow  out  1              value >= 10**BCD_DIGITS; bcd then holds value mod 10**BCD_DIGITS
//  lz_mask   out  BCD_DIGITS     bit d=1 -> digit d is a leading zero (bit 0 always 0)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, bcd=0, overflow=0, lz_mask=0.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : in_ready=1. On in_valid&&in_ready: latch bin into shift reg, clear digit regs, overflow=0,
//          bit counter=BIN_WIDTH-1, go SHIFT.
//   SHIFT: each cycle, per digit: if digit>=5 add 3 (4-bit, no carry), then shift the whole digit chain
//          left 1, LSB of digit 0 <- shift_reg MSB, shift_reg <<= 1. Bit shifted out of the top digit:
//          if 1, set overflow (sticky). After BIN_WIDTH shift cycles (counter reaches 0) go DONE.
//   DONE : out_valid=1, outputs stable. On out_ready go IDLE (out_valid=0 next cycle).
//  Latency: accept edge -> out_valid high exactly BIN_WIDTH cycles later. in_ready=0 in SHIFT and DONE;
//   max throughput one result per BIN_WIDTH+2 cycles. in_valid/bin ignored outside IDLE.
//  lz_mask computed in DONE from final digits: bit d=1 iff digits d..BCD_DIGITS-1 are all zero, d>=1.
//   Value 0 -> only digit 0 shown. lz_mask is not cleared by overflow.
//  bcd holds last result in IDLE until next result; out_valid alone qualifies it.
//  out_ready while not DONE: no effect. Bit counter width $clog2(BIN_WIDTH+1).
//  rst_n asserted mid-SHIFT/DONE: immediate return to reset values, in-flight result discarded.
//  BIN_WIDTH=1: single SHIFT cycle. Digits never exceed 9 when no overflow.
// STRUCTURE
//  Package bcd_conv_pkg: state enum (ST_IDLE, ST_SHIFT, ST_DONE), ADD3_THRESH=4'd5, ADD3_VAL=4'd3.
//  Sub-module dd_digit_cell: one 4-bit digit register with add-3 correction, shift-in bit, shift-out bit,
//   load-clear; instantiated BCD_DIGITS times in a generate chain. Top holds FSM, counter, shift reg,
//   overflow flag and lz_mask logic.
// TESTING
//  W=8,D=3: bin=255 accepted, out_ready=1 -> out_valid exactly 8 cycles later, bcd=12'h255, ovf=0, lz=3'b000.
//  W=8,D=3: bin=0 -> bcd=12'h000, lz_mask=3'b110; bin=7 -> bcd=12'h007, lz_mask=3'b110; bin=40 -> lz=3'b100.
//  W=8,D=2: bin=123 -> bcd=8'h23, overflow=1; then bin=99 -> bcd=8'h99, overflow=0 (flag not sticky).
//  Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/bcd held, in_ready=0, new in_valid ignored.
//  Reset: rst_n low during cycle 3 of SHIFT -> all outputs reset values same cycle; next conversion correct.
//  W=16,D=5: bins 65535, 10000, 9999, 1 -> 20'h65535, 20'h10000, 20'h09999, 20'h00001; latency 16 each.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// rtl/bcd_conv_pkg.sv - shared constants and helpers for the sequential binary-to-BCD converter
package bcd_conv_pkg;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Double-dabble correction: any digit of 5 or more gets 3 added before the shift
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    // 4-bit add-3 correction, no carry out of the nibble
    function automatic logic [3:0] add3_fix(input logic [3:0] d);
        return (d >= ADD3_THRESH) ? (d + ADD3_VAL) : d;
    endfunction

endpackage

// File: rtl/dd_digit_cell.sv
// rtl/dd_digit_cell.sv - one BCD digit of the double-dabble shift chain
module dd_digit_cell
    import bcd_conv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       shift_in,
    output logic [3:0] digit_next,
    output logic       shift_out
);

    logic [3:0] digit_q;
    logic [3:0] adj;

    // Correct then shift: the corrected MSB leaves towards the next digit
    always_comb begin
        adj        = add3_fix(digit_q);
        shift_out  = adj[3];
        digit_next = {adj[2:0], shift_in};
    end

    // Digit register: cleared on a new conversion, advanced on every shift cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else if (clear) begin
            digit_q <= 4'd0;
        end else if (shift_en) begin
            digit_q <= digit_next;
        end
    end

endmodule

// File: rtl/bcd_conv_seq.sv
// rtl/bcd_conv_seq.sv - sequential binary-to-BCD converter, one bit per clock, with handshake and blanking mask
module bcd_conv_seq
    import bcd_conv_pkg::*;
#(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    overflow,
    output logic [BCD_DIGITS-1:0]   lz_mask
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [BIN_WIDTH-1:0]    sr;
    logic [BCD_DIGITS:0]     chain;
    logic [4*BCD_DIGITS-1:0] bcd_next;
    logic [BCD_DIGITS-1:0]   lz_next;
    logic                    accept;
    logic                    shifting;
    logic                    last_shift;
    logic                    run_zero;

    assign accept     = (state == ST_IDLE) && in_valid;
    assign shifting   = (state == ST_SHIFT);
    assign last_shift = shifting && (cnt == '0);
    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);

    // Binary MSB feeds the ones digit; the top digit's carry-out is the overflow bit
    assign chain[0] = sr[BIN_WIDTH-1];

    genvar d;
    generate
        for (d = 0; d < BCD_DIGITS; d++) begin : g_digit
            dd_digit_cell u_cell (
                .clk        (clk),
                .rst_n      (rst_n),
                .clear      (accept),
                .shift_en   (shifting),
                .shift_in   (chain[d]),
                .digit_next (bcd_next[4*d +: 4]),
                .shift_out  (chain[d+1])
            );
        end
    endgenerate

    // Leading-zero mask from the final digits: digit d blanks when it and all above are zero
    always_comb begin
        lz_next  = '0;
        run_zero = 1'b1;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            run_zero   = run_zero && (bcd_next[4*i +: 4] == 4'd0);
            lz_next[i] = run_zero;
        end
    end

    // Control FSM: IDLE -> SHIFT (BIN_WIDTH cycles) -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (in_valid)   state <= ST_SHIFT;
                ST_SHIFT: if (cnt == '0)  state <= ST_DONE;
                ST_DONE:  if (out_ready)  state <= ST_IDLE;
                default:                  state <= ST_IDLE;
            endcase
        end
    end

    // Shift register, bit counter and sticky overflow for the conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            sr       <= bin;
            cnt      <= CNT_W'(BIN_WIDTH - 1);
            overflow <= 1'b0;
        end else if (shifting) begin
            sr  <= sr << 1;
            cnt <= cnt - 1'b1;
            if (chain[BCD_DIGITS]) begin
                overflow <= 1'b1;
            end
        end
    end

    // Result registers: captured on the last shift so they hold until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd     <= '0;
            lz_mask <= '0;
        end else if (last_shift) begin
            bcd     <= bcd_next;
            lz_mask <= lz_next;
        end
    end

endmodule
